// File: rtl/fpga_cfg_pkg.sv
// Shared types and width helpers for the configuration-chain sequencer.
package fpga_cfg_pkg;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } cfg_state_e;

    // Width of the shifted-bit counter: enough to hold 0..chain_len-1.
    function automatic int bit_cnt_width(input int chain_len);
        return (chain_len < 2) ? 1 : $clog2(chain_len);
    endfunction

    // Width of the pace counter: at least one bit even when pace is 1.
    function automatic int pace_cnt_width(input int pace);
        return (pace < 2) ? 1 : $clog2(pace);
    endfunction

endpackage

// File: rtl/fpga_cfg_pacer.sv
// Bit-rate pacer: while run is high it counts 0..PACE-1 and raises tick on the
// last count, giving exactly one tick per PACE cycles. Idle means count 0, so
// a new run always starts a full period.
module fpga_cfg_pacer
    import fpga_cfg_pkg::*;
#(
    parameter int PACE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int            CNT_W = pace_cnt_width(PACE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PACE - 1);

    logic [CNT_W-1:0] pace_cnt;

    // Count while running, wrap at the terminal value, hold at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pace_cnt <= '0;
        end else if (!run || pace_cnt == LAST) begin
            pace_cnt <= '0;
        end else begin
            pace_cnt <= pace_cnt + 1'b1;
        end
    end

    assign tick = run && (pace_cnt == LAST);

endmodule

// File: rtl/fpga_dffer.sv
// Enable D flip-flop with asynchronous active-high reset; the primitive the
// configuration chain and its shadow bank are built from.
module fpga_dffer (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    // Capture d only on enabled cycles; reset clears the flop immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fpga_cfg_chain_ctrl.sv
// Configuration-chain sequencer. Accepts a parallel word over valid/ready,
// shifts it MSB-first into an external flop chain (one bit per PACE cycles),
// captures the bits falling out of the chain tail as readback, then pulses
// the shadow-bank update enable and reports completion.
//
// Handshake: a word transfers on any rising edge where cfg_valid_i and
// cfg_ready_o are both high; cfg_ready_o is high exactly in IDLE and depends
// only on registered state, so the sender may hold valid (and data) as long
// as it likes and no word is ever queued while ready is low.
module fpga_cfg_chain_ctrl
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int PACE      = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cfg_valid_i,
    input  logic [CHAIN_LEN-1:0] cfg_data_i,
    output logic                 cfg_ready_o,
    input  logic                 abort_i,
    output logic                 shift_en_o,
    output logic                 shift_d_o,
    input  logic                 shift_q_i,
    output logic                 update_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic [CHAIN_LEN-1:0] rdback_o,
    output cfg_state_e           state_o
);

    localparam int               BIT_W    = bit_cnt_width(CHAIN_LEN);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

    cfg_state_e           state;
    logic [CHAIN_LEN-1:0] dreg;
    logic [CHAIN_LEN-1:0] creg;
    logic [CHAIN_LEN-1:0] rdback;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 aborted_q;
    logic                 tick;

    fpga_cfg_pacer #(
        .PACE (PACE)
    ) u_pacer (
        .clk  (clk_i),
        .rst  (reset_i),
        .run  (state == SHIFT),
        .tick (tick)
    );

    // Sequencer: accept, shift one bit per tick, update, report.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            dreg      <= '0;
            creg      <= '0;
            rdback    <= '0;
            bit_cnt   <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        dreg    <= cfg_data_i;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        dreg <= {dreg[CHAIN_LEN-2:0], 1'b0};
                        creg <= {creg[CHAIN_LEN-2:0], shift_q_i};
                        if (bit_cnt == LAST_BIT) begin
                            state <= UPDATE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // An abort still lets a coincident shift happen, but
                    // never reaches UPDATE, so the shadow bank stays intact.
                    if (abort_i) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end
                end
                UPDATE: begin
                    rdback <= creg;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign shift_en_o  = tick;
    assign shift_d_o   = (state == SHIFT) && dreg[CHAIN_LEN-1];
    assign update_en_o = (state == UPDATE);
    assign done_o      = (state == DONE);
    assign aborted_o   = aborted_q;
    assign rdback_o    = rdback;
    assign state_o     = state;

endmodule

// File: tb/tb_fpga_cfg_chain_ctrl.sv
// Bench for fpga_cfg_chain_ctrl: two instances (PACE=1 and PACE=3, 8-bit
// chain), each driving a chain and shadow bank of fpga_dffer flops. Directed
// loads push expected bits and end events into queues; a negedge monitor pops
// and compares whenever the DUT shifts, finishes or aborts.
module tb_fpga_cfg_chain_ctrl;
    import fpga_cfg_pkg::*;

    localparam int N     = 8;
    localparam int PACE0 = 1;
    localparam int PACE1 = 3;

    typedef struct {
        logic       is_abort;
        int         inst;
        logic [7:0] rdback;
        logic [7:0] shadow;
        int         lat;
        int         shifts;
    } exp_t;

    exp_t exp_q[$];
    logic exp_bit_q[$];
    int   gap_q[$];

    logic       clk = 1'b0;
    logic       reset_i;
    logic       chain_rst;
    logic       end_req = 1'b0;
    logic       cfg_valid [2];
    logic       abort [2];
    logic [7:0] cfg_data [2];
    logic       cfg_ready [2];
    logic       shift_en [2];
    logic       shift_d [2];
    logic       shift_q [2];
    logic       update_en [2];
    logic       busy [2];
    logic       done [2];
    logic       aborted [2];
    logic [7:0] rdback [2];
    logic [7:0] chain_q [2];
    logic [7:0] shadow_q [2];
    cfg_state_e st [2];

    int err_cnt;
    int chk_cnt;
    int cyc;
    int acc_cyc [2];
    int last_sh [2];
    int sh_cnt [2];
    int upd_cnt [2];
    logic prev_sh [2];
    logic prev_en [2];
    logic prev_d [2];

    // Clock generation.
    always #5 clk = ~clk;

    fpga_cfg_chain_ctrl #(.CHAIN_LEN(N), .PACE(PACE0)) u_dut0 (
        .clk_i(clk), .reset_i(reset_i), .cfg_valid_i(cfg_valid[0]),
        .cfg_data_i(cfg_data[0]), .cfg_ready_o(cfg_ready[0]), .abort_i(abort[0]),
        .shift_en_o(shift_en[0]), .shift_d_o(shift_d[0]), .shift_q_i(shift_q[0]),
        .update_en_o(update_en[0]), .busy_o(busy[0]), .done_o(done[0]),
        .aborted_o(aborted[0]), .rdback_o(rdback[0]), .state_o(st[0])
    );

    fpga_cfg_chain_ctrl #(.CHAIN_LEN(N), .PACE(PACE1)) u_dut1 (
        .clk_i(clk), .reset_i(reset_i), .cfg_valid_i(cfg_valid[1]),
        .cfg_data_i(cfg_data[1]), .cfg_ready_o(cfg_ready[1]), .abort_i(abort[1]),
        .shift_en_o(shift_en[1]), .shift_d_o(shift_d[1]), .shift_q_i(shift_q[1]),
        .update_en_o(update_en[1]), .busy_o(busy[1]), .done_o(done[1]),
        .aborted_o(aborted[1]), .rdback_o(rdback[1]), .state_o(st[1])
    );

    // Chain and shadow bank per instance, built from the flop primitive.
    for (genvar g = 0; g < 2; g++) begin : g_chain
        logic [N-1:0] cq;
        logic [N-1:0] sq;
        logic [N-1:0] cd;
        assign cd = {cq[N-2:0], shift_d[g]};
        for (genvar k = 0; k < N; k++) begin : g_bit
            fpga_dffer u_chain (.clk(clk), .rst(chain_rst), .en(shift_en[g]), .d(cd[k]), .q(cq[k]));
            fpga_dffer u_shadow (.clk(clk), .rst(chain_rst), .en(update_en[g]), .d(cq[k]), .q(sq[k]));
        end
        assign shift_q[g]  = cq[N-1];
        assign chain_q[g]  = cq;
        assign shadow_q[g] = sq;
    end

    function automatic int pace_of(input int g);
        return (g == 0) ? PACE0 : PACE1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_bits(input logic [7:0] data, input int count);
        for (int i = 7; i > 7 - count; i--) exp_bit_q.push_back(data[i]);
    endtask

    task automatic push_load(input int g, input logic [7:0] data, input logic [7:0] rd,
                             input logic [7:0] sh, input int lat);
        exp_t e;
        e.is_abort = 1'b0; e.inst = g; e.rdback = rd; e.shadow = sh; e.lat = lat; e.shifts = N;
        exp_q.push_back(e);
        push_bits(data, N);
    endtask

    task automatic push_abort(input int g, input logic [7:0] data, input int nbits,
                              input logic [7:0] rd, input logic [7:0] sh);
        exp_t e;
        e.is_abort = 1'b1; e.inst = g; e.rdback = rd; e.shadow = sh; e.lat = 0; e.shifts = nbits;
        exp_q.push_back(e);
        push_bits(data, nbits);
    endtask

    // Returns 1ns after the accepting edge (valid must already be high).
    task automatic wait_accept(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_bit_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_i = 1'b1; chain_rst = 1'b1;
        cfg_valid[0] = 1'b0; cfg_valid[1] = 1'b0;
        abort[0] = 1'b0; abort[1] = 1'b0;
        cfg_data[0] = 8'h00; cfg_data[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0; chain_rst = 1'b0;
        @(posedge clk);
        #1;

        // Abort while idle: no effect.
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        abort[0] = 1'b0;

        // Load 0xA5 then 0x3C back-to-back with valid held high.
        push_load(0, 8'hA5, 8'h00, 8'hA5, N * PACE0 + 2);
        push_load(0, 8'h3C, 8'hA5, 8'h3C, N * PACE0 + 2);
        cfg_data[0] = 8'hA5; cfg_valid[0] = 1'b1;
        wait_accept(0);
        cfg_data[0] = 8'h3C;
        gap_q.push_back(N * PACE0 + 3);
        wait_accept(0);
        cfg_valid[0] = 1'b0;
        wait_drain();

        // PACE=3 instance, load 0xFF into a zeroed chain.
        push_load(1, 8'hFF, 8'h00, 8'hFF, N * PACE1 + 2);
        cfg_data[1] = 8'hFF; cfg_valid[1] = 1'b1;
        wait_accept(1);
        cfg_valid[1] = 1'b0;
        wait_drain();

        // Abort 0x0F on its 4th shift cycle: chain 0x3C -> 0xC0, shadow kept.
        push_abort(0, 8'h0F, 4, 8'hA5, 8'h3C);
        cfg_data[0] = 8'h0F; cfg_valid[0] = 1'b1;
        wait_accept(0);
        cfg_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        abort[0] = 1'b0;
        wait_drain();

        // Reset mid-shift after two bits of 0x55: chain 0xC0 -> 0x01.
        push_bits(8'h55, 2);
        cfg_data[0] = 8'h55; cfg_valid[0] = 1'b1;
        wait_accept(0);
        cfg_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        push_load(0, 8'h81, 8'h01, 8'h81, N * PACE0 + 2);
        cfg_data[0] = 8'h81; cfg_valid[0] = 1'b1;
        wait_accept(0);
        cfg_valid[0] = 1'b0;
        wait_drain();

        // Input noise during SHIFT must not disturb the latched 0x5A.
        push_load(0, 8'h5A, 8'h81, 8'h5A, N * PACE0 + 2);
        cfg_data[0] = 8'h5A; cfg_valid[0] = 1'b1;
        wait_accept(0);
        cfg_data[0] = 8'hFF; cfg_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        cfg_data[0] = 8'h00; cfg_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        cfg_data[0] = 8'hC3; cfg_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid[0] = 1'b0;
        wait_drain();

        end_req = 1'b1;
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        chk_cnt++;
        err_cnt++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    initial begin
        exp_t e;
        err_cnt = 0; chk_cnt = 0; cyc = 0;
        for (int g = 0; g < 2; g++) begin
            acc_cyc[g] = 0; last_sh[g] = 0; sh_cnt[g] = 0; upd_cnt[g] = 0;
            prev_sh[g] = 1'b0; prev_en[g] = 1'b0; prev_d[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (reset_i) begin
                    check("reset_outputs",
                          {shift_en[g], shift_d[g], update_en[g], busy[g], done[g],
                           aborted[g], cfg_ready[g], rdback[g]},
                          {7'b0000001, 8'h00});
                    prev_sh[g] = 1'b0;
                end else begin
                    if (cfg_valid[g] && cfg_ready[g]) begin
                        if (g == 0 && gap_q.size() > 0)
                            check("accept_gap", cyc - acc_cyc[g], gap_q.pop_front());
                        acc_cyc[g] = cyc; last_sh[g] = cyc; sh_cnt[g] = 0; upd_cnt[g] = 0;
                    end
                    if (shift_en[g]) begin
                        if (exp_bit_q.size() == 0)
                            fail("unexpected_shift", "shift_en_o=1 but no bit is pending");
                        else
                            check("shift_d", shift_d[g], exp_bit_q.pop_front());
                        check("shift_spacing", cyc - last_sh[g], pace_of(g));
                        last_sh[g] = cyc;
                        sh_cnt[g]++;
                    end
                    if (update_en[g]) upd_cnt[g]++;
                    if (st[g] == SHIFT && prev_sh[g] && !prev_en[g])
                        check("shift_d_stable", shift_d[g], prev_d[g]);
                    prev_sh[g] = (st[g] == SHIFT);
                    prev_en[g] = shift_en[g];
                    prev_d[g]  = shift_d[g];
                    if (done[g] || aborted[g]) begin
                        if (exp_q.size() == 0) begin
                            fail("unexpected_end", "done_o/aborted_o pulsed with nothing expected");
                        end else begin
                            e = exp_q.pop_front();
                            check("end_kind", aborted[g], e.is_abort);
                            check("end_inst", g, e.inst);
                            check("rdback", rdback[g], e.rdback);
                            check("shadow", shadow_q[g], e.shadow);
                            check("shift_pulses", sh_cnt[g], e.shifts);
                            check("update_pulses", upd_cnt[g], e.is_abort ? 0 : 1);
                            if (e.is_abort) begin
                                check("ready_after_abort", cfg_ready[g], 1);
                            end else begin
                                check("done_latency", cyc - acc_cyc[g], e.lat);
                                check("busy_in_done", busy[g], 1);
                            end
                        end
                    end
                end
            end
            if (end_req || cyc > 5000) begin
                if (!end_req) fail("timeout", "stimulus did not complete in 5000 cycles");
                check("exp_queue_empty", exp_q.size(), 0);
                check("bit_queue_empty", exp_bit_q.size(), 0);
                $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
                $finish;
            end
        end
    end

endmodule

// File: doc/fpga_cfg_chain_ctrl.md
Name: fpga_cfg_chain_ctrl

Overview:
Sequencer for a serial configuration chain built from enable/async-reset DFF primitives.
- The chain is CHAIN_LEN shift flops, all clocked by shift_en_o, followed by a parallel shadow bank clocked by update_en_o.
- The block accepts a parallel configuration word over a valid/ready handshake and shifts it into the chain serially, one bit per PACE cycles.
- It then pulses update to transfer the chain into the shadow bank, and returns the previous chain contents as readback.

Parameters:
CHAIN_LEN, 16, number of flops in the chain; legal range ≥ 2.
PACE, 1, clock cycles per shifted bit; legal range ≥ 1.

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous reset, active-high
cfg_valid_i  in  1  request to load cfg_data_i
cfg_data_i  in  CHAIN_LEN  word to load; bit k lands in chain flop k
cfg_ready_o  out  1  block can accept a word
abort_i  in  1  cancels an in-progress shift
shift_en_o  out  1  clock enable for every chain flop
shift_d_o  out  1  serial data into chain flop 0
shift_q_i  in  1  chain tail (output of flop CHAIN_LEN-1)
update_en_o  out  1  clock enable for the shadow bank
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse when a load completes
aborted_o  out  1  one-cycle pulse when a load is aborted
rdback_o  out  CHAIN_LEN  chain contents before the last completed load

Behaviour:
- Reset (asynchronous, reset_i=1):
  - State is IDLE; all counters and the data shift register are 0.
  - Outputs: shift_en_o=0, shift_d_o=0, update_en_o=0, busy_o=0, done_o=0, aborted_o=0, rdback_o=0.
  - cfg_ready_o=1, because it is decoded from state IDLE.
- States: IDLE, SHIFT, UPDATE, DONE. All control outputs are decoded from registered state and counters only, with no combinational path from any input.
- IDLE:
  - cfg_ready_o=1.
  - cfg_valid_i=1 at a rising edge: cfg_data_i is latched into data register dreg, pace_cnt and bit_cnt are cleared, and the state becomes SHIFT.
  - Input data is sampled only on the accepting edge.
- SHIFT:
  - busy_o=1.
  - pace_cnt counts 0..PACE-1 and wraps.
  - shift_en_o=1 only when pace_cnt==PACE-1, i.e. exactly one cycle per bit.
  - shift_d_o = dreg[CHAIN_LEN-1], held stable for the whole PACE period.
- Each shift_en_o=1 cycle:
  - dreg shifts left by one.
  - shift_q_i is captured into the LSB of capture register creg, which also shifts left.
  - bit_cnt increments.
- First bit transmitted is cfg_data_i[CHAIN_LEN-1]; first bit captured is the old flop CHAIN_LEN-1.
- After CHAIN_LEN shifts, creg[k] equals the old content of flop k.
- On the shift cycle where bit_cnt==CHAIN_LEN-1, the state becomes UPDATE.
- UPDATE: exactly one cycle, with update_en_o=1, busy_o=1; next state DONE.
- DONE: exactly one cycle.
  - done_o=1, busy_o=1.
  - rdback_o is loaded from creg on entry to DONE, so it is valid while done_o=1.
  - Next state IDLE.
- Latency: the accepting edge to done_o high is CHAIN_LEN*PACE+2 cycles. cfg_ready_o stays low from the cycle after acceptance until the cycle after DONE.
- Back-to-back: cfg_valid_i held high is accepted on the first IDLE cycle after DONE. The minimum load period is therefore CHAIN_LEN*PACE+3 cycles.
- Abort:
  - abort_i=1 in SHIFT: next state IDLE, no update_en_o, aborted_o pulses for 1 cycle, rdback_o is unchanged. The partially shifted chain is left as is; the shadow bank is untouched.
  - abort_i on the same cycle as a shift_en_o=1 cycle: that shift still occurs, then the state moves to IDLE.
  - abort_i in IDLE, UPDATE or DONE: ignored.
- cfg_valid_i while not ready: ignored; no queuing.
- Reset mid-operation: returns immediately to the reset values above; update_en_o is never issued.
- Widths: bit_cnt is $clog2(CHAIN_LEN) bits and pace_cnt is max(1,$clog2(PACE)) bits; neither counter ever wraps past its terminal value.

Decomposition:
- Package fpga_cfg_pkg holds the state enum cfg_state_e (IDLE, SHIFT, UPDATE, DONE) and localparam helper functions for the counter widths.
- One sub-module, fpga_cfg_pacer, holds the PACE counter and emits a one-cycle tick; shift_en_o = tick while in SHIFT.
- The bench instantiates CHAIN_LEN fpga_dffer flops as the chain model and CHAIN_LEN more as the shadow bank. These instances are not part of this block.

Test Plan:
1. CHAIN_LEN=8, PACE=1, chain reset to 0, load 0xA5 → 8 consecutive shift_en_o cycles with shift_d_o sequence 1,0,1,0,0,1,0,1; then update_en_o 1 cycle; done_o 10 cycles after acceptance; shadow=0xA5; rdback_o=0x00.
2. Second load 0x3C after case 1 → shadow=0x3C, rdback_o=0xA5; with cfg_valid_i held high, acceptance occurs exactly 11 cycles after the first acceptance.
3. PACE=3, load 0xFF → shift_en_o high on every 3rd cycle, 8 pulses; shift_d_o stable across each period; done_o 26 cycles after acceptance.
4. abort_i at the 4th shift cycle of load 0x0F → aborted_o pulse, no update_en_o, no done_o, shadow unchanged, rdback_o unchanged, cfg_ready_o=1 next cycle.
5. reset_i asserted mid-SHIFT, asynchronously between edges → all outputs return to reset values immediately, cfg_ready_o=1; a subsequent load of 0x81 completes normally.
6. cfg_valid_i toggled and cfg_data_i changed during SHIFT → ignored; the loaded value equals the word latched at acceptance.
